// File: rtl/meg_bl_gate_meter.sv
//==============================================================================
// Module   : meg_bl_gate_meter
// Purpose  : Gated pulse-width meter. Counts synchronised Inp-high cycles
//            inside each REF window and publishes the count on Q at gate close.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module meg_bl_gate_meter #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             st,
    input  logic             Inp,
    input  logic             REF,
    output logic [WIDTH-1:0] Q
);

    localparam logic [WIDTH-1:0] c_ACC_MAX = '1;
    localparam logic [WIDTH-1:0] c_ZERO    = '0;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_GATE     = 2'd1,
        S_WAIT_LOW = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] inp_sync_q;
    logic [SYNC_STAGES-1:0] ref_sync_q;
    logic                   ref_dly_q;
    logic [WIDTH-1:0]       acc_q, acc_d;
    logic [WIDTH-1:0]       q_q, q_d;

    logic                   w_inp_s;
    logic                   w_ref_s;
    logic                   w_rise;
    logic [WIDTH-1:0]       w_inp_ext;
    logic [WIDTH-1:0]       w_acc_sat;

    // Both chains share one depth so Inp keeps its alignment to the gate.
    always_ff @(posedge clk) begin
        if (rst) begin
            inp_sync_q <= '0;
            ref_sync_q <= '0;
            ref_dly_q  <= 1'b0;
        end else begin
            inp_sync_q <= {inp_sync_q[SYNC_STAGES-2:0], Inp};
            ref_sync_q <= {ref_sync_q[SYNC_STAGES-2:0], REF};
            ref_dly_q  <= w_ref_s;
        end
    end

    assign w_inp_s   = inp_sync_q[SYNC_STAGES-1];
    assign w_ref_s   = ref_sync_q[SYNC_STAGES-1];
    assign w_rise    = w_ref_s & ~ref_dly_q;
    assign w_inp_ext = {{(WIDTH-1){1'b0}}, w_inp_s};
    assign w_acc_sat = (acc_q == c_ACC_MAX) ? c_ACC_MAX : (acc_q + w_inp_ext);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= c_ZERO;
            q_q     <= c_ZERO;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        q_d     = q_q;
        if (st) begin
            // Discard any gate in progress and wait for REF to drop first.
            acc_d   = c_ZERO;
            q_d     = c_ZERO;
            state_d = S_WAIT_LOW;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_rise) begin
                        acc_d   = w_inp_ext;
                        state_d = S_GATE;
                    end
                end
                S_GATE: begin
                    if (w_ref_s) begin
                        acc_d = w_acc_sat;
                    end else begin
                        q_d     = acc_q;
                        acc_d   = c_ZERO;
                        state_d = S_IDLE;
                    end
                end
                S_WAIT_LOW: begin
                    if (!w_ref_s) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign Q = q_q;

endmodule

`default_nettype wire

// File: tb/tb_meg_bl_gate_meter.sv
//==============================================================================
// Module   : tb_meg_bl_gate_meter
// Purpose  : Directed self-checking bench for the gated pulse-width meter.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_meg_bl_gate_meter;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             st;
    logic             Inp;
    logic             REF;
    logic [WIDTH-1:0] Q;

    int               checks;
    int               errors;
    logic [WIDTH-1:0] last_q;
    logic [WIDTH-1:0] sb[$];

    meg_bl_gate_meter #(
        .WIDTH      (WIDTH),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .st (st),
        .Inp(Inp),
        .REF(REF),
        .Q  (Q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the edge; Q is sampled at that same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                         input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One full gate: REF high ref_n cycles, Inp high for the first inp_n of them.
    task automatic run_gate(input string tag, input int ref_n, input int inp_n);
        logic [WIDTH-1:0] e;
        REF = 1'b1;
        for (int i = 0; i < ref_n; i++) begin
            Inp = (i < inp_n);
            tick();
            check({tag, "_hold_gate"}, Q, last_q);
        end
        REF = 1'b0;
        Inp = 1'b0;
        sb.push_back((inp_n > 255) ? 8'd255 : 8'(inp_n));
        tick();
        check({tag, "_hold_lat1"}, Q, last_q);
        tick();
        check({tag, "_hold_lat2"}, Q, last_q);
        tick();
        e = sb.pop_front();
        check({tag, "_publish"}, Q, e);
        last_q = e;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        last_q = '0;
        rst = 1'b1;
        st  = 1'b0;
        Inp = 1'b1;
        REF = 1'b1;

        // Reset with both inputs high: nothing may be published.
        for (int i = 0; i < 5; i++) begin
            tick();
            check("reset_q", Q, 8'd0);
        end

        // REF already high at release is seen as a rise and measured.
        rst = 1'b0;
        run_gate("basic", 10, 5);
        for (int i = 0; i < 500; i++) begin
            tick();
            if (Q !== 8'd5 || (i % 100) == 0) check("basic_hold500", Q, 8'd5);
        end

        run_gate("saturate", 300, 300);
        tick();

        run_gate("empty", 8, 0);
        tick();
        run_gate("b2b_first", 10, 3);
        tick();
        run_gate("b2b_second", 10, 7);
        tick();

        // Soft restart mid-gate clears Q at once and the gate is dropped.
        REF = 1'b1;
        Inp = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        Inp = 1'b0;
        st  = 1'b1;
        sb.push_back(8'd0);
        tick();
        check("st_clear", Q, sb.pop_front());
        st = 1'b0;
        last_q = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("st_gate_open_hold", Q, last_q);
        end
        REF = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("st_no_publish", Q, last_q);
        end
        run_gate("after_st", 10, 6);
        tick();

        // rst wins over st; REF high at release must still be measured.
        rst = 1'b1;
        st  = 1'b1;
        REF = 1'b1;
        Inp = 1'b1;
        tick();
        tick();
        check("rst_over_st", Q, 8'd0);
        last_q = '0;
        rst = 1'b0;
        st  = 1'b0;
        run_gate("ref_at_release", 6, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
